// File: rtl/effect_driver_if.sv
// Opcode handshake between the opcode sequencer (master) and effect_driver (slave).
interface effect_driver_if;
  logic       op_valid;
  logic [3:0] op_in;
  logic       op_ready;

  modport master (output op_valid, output op_in, input op_ready);
  modport slave  (input op_valid, input op_in, output op_ready);
endinterface

// File: rtl/effect_driver.sv
// effect_driver: buffers 4-bit decoration opcodes in a small FIFO and executes
// them one at a time, driving lamp, sound and movement outputs.
// Optional build macro EFFECT_COUNT_EN adds an 8-bit saturating effect_count
// output counting the sound/movement effects started while powered.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_OFF   | decoration off; only an ON opcode powers up, others discarded
// ST_IDLE  | powered, waiting for the next opcode
// ST_SOUND | sound_out asserted, counting down SOUND_CYCLES
// ST_MOVE  | move_out asserted, counting down MOVE_CYCLES
module effect_driver #(
  parameter int DEPTH        = 4,
  parameter int SOUND_CYCLES = 8,
  parameter int MOVE_CYCLES  = 6,
  parameter int CW           = 8
) (
  input  logic            clk,
  input  logic            rst,
  effect_driver_if.slave  bus,
  output logic            powered,
  output logic [2:0]      color_out,
  output logic [2:0]      sound_out,
  output logic [2:0]      move_out,
  output logic            busy
`ifdef EFFECT_COUNT_EN
  ,
  output logic [7:0]      effect_count
`endif
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_SOUND = 2'd2;
  localparam logic [1:0] ST_MOVE  = 2'd3;

  localparam logic [3:0] OP_ON    = 4'b0000;
  localparam logic [3:0] OP_RESET = 4'b0001;

  localparam logic [AW:0]   PTR_ONE    = 1;
  localparam logic [CW-1:0] CNT_ONE    = 1;
  localparam logic [CW-1:0] SOUND_LOAD = CW'(SOUND_CYCLES - 1);
  localparam logic [CW-1:0] MOVE_LOAD  = CW'(MOVE_CYCLES - 1);

  logic [3:0]    mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [3:0]    head;
  logic [1:0]    cls;
  logic [1:0]    sel;
  logic [2:0]    sel_onehot;
  logic [1:0]    state;
  logic [CW-1:0] count;

  // The extra pointer bit distinguishes full from empty when the indices match.
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign bus.op_ready = !full;
  assign push         = bus.op_valid && !full;
  assign pop          = !empty && ((state == ST_OFF) || (state == ST_IDLE));
  assign head         = mem[rd_ptr[AW-1:0]];
  assign cls          = head[3:2];
  assign sel          = head[1:0];
  assign busy         = !empty || (state == ST_SOUND) || (state == ST_MOVE);

  // Selector field to one-hot output code; sel=3 is a NO-OP in every class.
  always_comb begin
    sel_onehot = 3'b000;
    case (sel)
      2'd0:    sel_onehot = 3'b001;
      2'd1:    sel_onehot = 3'b010;
      2'd2:    sel_onehot = 3'b100;
      default: sel_onehot = 3'b000;
    endcase
  end

  // FIFO pointers; push and pop in the same cycle both advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // FIFO storage; contents need no reset because the pointers gate every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= bus.op_in;
  end

  // Execution FSM: the popped opcode takes effect on the same edge it leaves the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_OFF;
      count     <= '0;
      powered   <= 1'b0;
      color_out <= '0;
      sound_out <= '0;
      move_out  <= '0;
    end else begin
      case (state)
        ST_OFF: begin
          if (pop && (head == OP_ON)) begin
            powered <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (pop) begin
            if (head == OP_RESET) begin
              powered   <= 1'b0;
              color_out <= '0;
              state     <= ST_OFF;
            end else if (sel_onehot != 3'b000) begin
              case (cls)
                2'b01: color_out <= sel_onehot;
                2'b10: begin
                  sound_out <= sel_onehot;
                  count     <= SOUND_LOAD;
                  state     <= ST_SOUND;
                end
                2'b11: begin
                  move_out <= sel_onehot;
                  count    <= MOVE_LOAD;
                  state    <= ST_MOVE;
                end
                default: ;
              endcase
            end
          end
        end
        ST_SOUND, ST_MOVE: begin
          if (count == '0) begin
            sound_out <= '0;
            move_out  <= '0;
            state     <= ST_IDLE;
          end else begin
            count <= count - CNT_ONE;
          end
        end
        default: state <= ST_OFF;
      endcase
    end
  end

`ifdef EFFECT_COUNT_EN
  // Saturating count of effects started; a popped RESET clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      effect_count <= '0;
    end else if (pop && (head == OP_RESET)) begin
      effect_count <= '0;
    end else if (pop && (state == ST_IDLE) && cls[1] && (sel_onehot != 3'b000)
                 && (effect_count != 8'hFF)) begin
      effect_count <= effect_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_effect_driver.sv
// Testbench for effect_driver: directed scenarios plus random traffic, every
// cycle compared against a queue-based behavioural model of the decoration.
module tb_effect_driver;

  localparam int DEPTH        = 4;
  localparam int SOUND_CYCLES = 8;
  localparam int MOVE_CYCLES  = 6;

  logic       clk;
  logic       rst;
  logic       powered;
  logic [2:0] color_out;
  logic [2:0] sound_out;
  logic [2:0] move_out;
  logic       busy;
`ifdef EFFECT_COUNT_EN
  logic [7:0] effect_count;
`endif

  effect_driver_if bus ();

  effect_driver #(
    .DEPTH(DEPTH), .SOUND_CYCLES(SOUND_CYCLES), .MOVE_CYCLES(MOVE_CYCLES), .CW(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .powered(powered),
    .color_out(color_out),
    .sound_out(sound_out),
    .move_out(move_out),
    .busy(busy)
`ifdef EFFECT_COUNT_EN
    ,
    .effect_count(effect_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: opcodes waiting, lamps, and remaining effect cycles.
  logic [3:0] q[$];
  int         m_pow;
  int         m_col;
  int         m_snd;
  int         m_mov;
  int         m_cnt;
  int         remain;
  bit         last_push;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int onehot(input logic [1:0] s);
    return (s == 2'd3) ? 0 : (1 << s);
  endfunction

  // Apply one clock edge of the decoration rules to the model.
  task automatic model_step();
    bit         do_push;
    logic [3:0] in_op;
    logic [3:0] op;
    do_push   = 1'b0;
    in_op     = bus.op_in;
    if (rst) begin
      q.delete();
      m_pow = 0; m_col = 0; m_snd = 0; m_mov = 0; m_cnt = 0; remain = 0;
    end else begin
      do_push = bus.op_valid && (q.size() < DEPTH);
      if (remain > 0) begin
        remain--;
        if (remain == 0) begin
          m_snd = 0;
          m_mov = 0;
        end
      end else if (q.size() > 0) begin
        op = q.pop_front();
        if (op == 4'b0001) m_cnt = 0;
        if (m_pow == 0) begin
          if (op == 4'b0000) m_pow = 1;
        end else if (op == 4'b0001) begin
          m_pow = 0;
          m_col = 0;
        end else if (op[1:0] != 2'd3) begin
          case (op[3:2])
            2'b01: m_col = onehot(op[1:0]);
            2'b10: begin
              m_snd  = onehot(op[1:0]);
              remain = SOUND_CYCLES;
              if (m_cnt < 255) m_cnt++;
            end
            2'b11: begin
              m_mov  = onehot(op[1:0]);
              remain = MOVE_CYCLES;
              if (m_cnt < 255) m_cnt++;
            end
            default: ;
          endcase
        end
      end
      if (do_push) q.push_back(in_op);
    end
    last_push = do_push;
  endtask

  // One clock: model and DUT advance on the edge, outputs compared 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("op_ready", int'(bus.op_ready), int'(q.size() < DEPTH));
    chk("powered", int'(powered), m_pow);
    chk("color_out", int'(color_out), m_col);
    chk("sound_out", int'(sound_out), m_snd);
    chk("move_out", int'(move_out), m_mov);
    chk("busy", int'(busy), int'((q.size() > 0) || (remain > 0)));
`ifdef EFFECT_COUNT_EN
    chk("effect_count", int'(effect_count), m_cnt);
`endif
  endtask

  // Offer one opcode, holding it while the FIFO is full.
  task automatic push_op(input logic [3:0] o);
    bus.op_valid = 1'b1;
    bus.op_in    = o;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (last_push) break;
    end
    if (!last_push) chk("push_timeout", 1, 0);
    bus.op_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000 && ((q.size() > 0) || (remain > 0)); i++) tick();
    if ((q.size() > 0) || (remain > 0)) chk("idle_timeout", 1, 0);
    tick();
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [3:0] r_op;

  initial begin
    rst          = 1'b1;
    bus.op_valid = 1'b0;
    bus.op_in    = 4'h0;
    q.delete();
    m_pow = 0; m_col = 0; m_snd = 0; m_mov = 0; m_cnt = 0; remain = 0;
    last_push = 1'b0;

    // Reset state, then ON and GREEN.
    tick();
    rst = 1'b0;
    push_op(4'h0);
    push_op(4'h4);
    wait_idle();
    chk("green_after_on", int'(color_out), 1);
    chk("idle_not_busy", int'(busy), 0);

    // GREEN, PURPLE, NO-OP, MOVEJAW; lamp must hold through the movement.
    push_op(4'h4);
    push_op(4'h5);
    push_op(4'hF);
    push_op(4'hD);
    wait_idle();
    chk("purple_held", int'(color_out), 2);

    // Fill the FIFO behind a BOO, three times round to wrap the pointers.
    for (int f = 0; f < 3; f++) begin
      push_op(4'hA);
      push_op(4'h6);
      push_op(4'h5);
      push_op(4'hF);
      push_op(4'h8);
      push_op(4'hE);
      wait_idle();
    end

    // While OFF: GREEN and BOO discarded, then ON and ORANGE.
    push_op(4'h1);
    push_op(4'h4);
    push_op(4'hA);
    push_op(4'h0);
    push_op(4'h6);
    wait_idle();
    chk("orange_after_off", int'(color_out), 4);

    // Reset in the middle of FOG with two entries queued.
    push_op(4'hE);
    push_op(4'h4);
    push_op(4'h5);
    for (int i = 0; i < 50 && remain != MOVE_CYCLES - 2; i++) tick();
    reset_pulse();
    chk("rst_mid_move", int'(move_out), 0);
    chk("rst_mid_ready", int'(bus.op_ready), 1);
    wait_idle();

`ifdef EFFECT_COUNT_EN
    push_op(4'h0);
    push_op(4'h8);
    push_op(4'hC);
    push_op(4'h4);
    wait_idle();
    chk("count_two", int'(effect_count), 2);
    push_op(4'h1);
    wait_idle();
    chk("count_cleared", int'(effect_count), 0);
    push_op(4'h0);
    for (int i = 0; i < 300; i++) push_op(4'hA);
    wait_idle();
    chk("count_saturated", int'(effect_count), 255);
    reset_pulse();
`endif

    // Random traffic with occasional resets; the source honours the hold rule.
    for (int c = 0; c < 3000; c++) begin
      if (!(bus.op_valid && !last_push)) begin
        bus.op_valid = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 9))
          0, 1:    r_op = 4'h0;
          2:       r_op = 4'h1;
          default: r_op = 4'($urandom_range(0, 15));
        endcase
        bus.op_in = r_op;
      end
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst          = 1'b0;
    bus.op_valid = 1'b0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/effect_driver.md
Name: effect_driver

Overview:
- Downstream consumer of the opcode sequencer in the decoration breadboard.
- Accepts 4-bit decoration opcodes over a valid/ready handshake and buffers them in a small FIFO.
- Executes opcodes one at a time:
  - color opcodes latch a one-hot lamp output;
  - sound and movement opcodes assert one-hot actuator outputs for a fixed number of cycles;
  - ON and RESET opcodes control power state.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
SOUND_CYCLES, 8, cycles a sound output stays asserted (>=1)
MOVE_CYCLES, 6, cycles a movement/effect output stays asserted (>=1)
CW, 8, duration counter width; SOUND_CYCLES and MOVE_CYCLES must be < 2**CW

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous active-high reset
op_valid  input  1  opcode offered this cycle
op_in  input  4  opcode {class[1:0], sel[1:0]}
op_ready  output  1  FIFO can accept; equals !full
powered  output  1  decoration is ON
color_out  output  3  one-hot lamp {ORANGE, PURPLE, GREEN}
sound_out  output  3  one-hot sound {BOO, CACKLING, SCREAMING}
move_out  output  3  one-hot effect {FOG, MOVEJAW, WAVEHANDS}
busy  output  1  FIFO non-empty or state is SOUND/MOVE

Behaviour:
- Reset (rst=1 at posedge, any state):
  - FIFO flushed, state=OFF, counter=0.
  - powered=0, color_out=0, sound_out=0, move_out=0, op_ready=1, busy=0.
  - Reset mid-effect aborts the effect immediately; outputs are 0 after that edge.
- Handshake:
  - Push occurs when op_valid && op_ready at posedge.
  - Source holds op_in stable while op_valid && !op_ready.
  - op_ready=0 when full, even if a pop occurs the same cycle; no push-through when full.
- FIFO:
  - Circular buffer with log2(DEPTH)+1-bit pointers; pointers wrap modulo DEPTH.
  - A push and a pop in the same cycle (not full) are both performed.
  - No fall-through: an opcode pushed at edge k executes no earlier than edge k+1.
- Pop: occurs at a posedge when state is OFF or IDLE and the FIFO is non-empty. The popped opcode takes effect at that same edge.
- Opcode decode:
  - 0000 ON, 0001 RESET.
  - 0100 GREEN, 0101 PURPLE, 0110 ORANGE.
  - 1000 SCREAMING, 1001 CACKLING, 1010 BOO.
  - 1100 WAVEHANDS, 1101 MOVEJAW, 1110 FOG.
  - 0010, 0011, 0111, 1011, 1111 are NO-OP.
- FSM states OFF, IDLE, SOUND, MOVE:
  - OFF:
    - Popped ON: powered=1, go to IDLE.
    - Any other popped opcode is discarded (one cycle each); stay OFF.
  - IDLE, by popped opcode:
    - Color: color_out = new one-hot (replaces previous); stay IDLE.
    - Sound: sound_out = one-hot, counter=SOUND_CYCLES-1; go to SOUND.
    - Movement: move_out = one-hot, counter=MOVE_CYCLES-1; go to MOVE.
    - RESET: powered=0, color_out=0; go to OFF. Remaining FIFO contents are kept.
    - ON or NO-OP: consumed, no output change.
  - SOUND/MOVE:
    - No pops.
    - If counter==0: clear sound_out/move_out and go to IDLE; otherwise decrement.
    - Result: the output is high for exactly SOUND_CYCLES / MOVE_CYCLES cycles.
    - The earliest next pop is the edge after the return to IDLE.
- Invariants:
  - At most one of sound_out/move_out is non-zero.
  - Each output vector is 0 or one-hot.
  - color_out holds across sound/move.

Optional Feature:
- Macro: EFFECT_COUNT_EN.
- When defined:
  - Adds output port effect_count [7:0].
  - effect_count increments by 1 on each pop that starts a SOUND or MOVE (powered only).
  - Saturates at 255; cleared by rst and by a popped RESET opcode.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- rst=1 for 1 cycle, then push ON, GREEN:
  - powered=1 one edge after ON is written;
  - color_out=3'b001 on the following edge;
  - busy=0 afterwards.
- From powered, push GREEN, PURPLE, 1111, MOVEJAW (data word 0xDF54, nibble 0 first):
  - color_out goes 001 then 010;
  - NO-OP consumes one cycle;
  - move_out=3'b010 for exactly 6 cycles, then 0;
  - color_out stays 010 throughout.
- Fill FIFO while in SOUND (BOO, then 5 pushes with DEPTH=4):
  - op_ready=0 after the 4th stored entry; the 5th is held by the source;
  - op_ready returns to 1 the cycle after the first pop following sound_out=3'b100 for 8 cycles;
  - all 4 entries then execute in order; pointer wrap verified over 3 fill cycles.
- While OFF, push GREEN, BOO, ON, ORANGE:
  - GREEN and BOO discarded with no output change;
  - powered=1 after ON;
  - color_out=3'b100 one edge later.
- Assert rst for 1 cycle in the middle of FOG (cycle 3 of 6) with 2 entries queued:
  - next edge: move_out=0, powered=0, busy=0, op_ready=1;
  - queued entries never execute.
- With EFFECT_COUNT_EN:
  - ON, SCREAMING, WAVEHANDS, GREEN → effect_count=2;
  - then RESET → 0;
  - 300 effects while powered → saturates at 255.
